// File: rtl/hash_arb_pkg.sv
// rtl/hash_arb_pkg.sv - shared types and constants for the hash table arbiter
package hash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_INSERT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [REQ_IDX_W-1:0] grant_idx,
  output logic                 any_grant
);

  logic [REQ_IDX_W-1:0] idx;

  // Scan from ptr upward; NUM_REQ is a power of two so index wrap is free truncation
  always_comb begin
    idx       = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + REQ_IDX_W'(i);
      if (!any_grant && req[idx]) begin
        any_grant = 1'b1;
        grant_idx = idx;
      end
    end
    grant = NUM_REQ'(any_grant) << grant_idx;
  end

endmodule

// File: rtl/hash_table_arbiter.sv
// rtl/hash_table_arbiter.sv - round-robin sharing of a single-ported hash table
module hash_table_arbiter
  import hash_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REQ_IDX_W   = 2,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_insert,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic                           resp_found,
  output logic [VALUE_WIDTH-1:0]         resp_value,
  output logic [KEY_WIDTH-1:0]           tbl_key,
  output logic [VALUE_WIDTH-1:0]         tbl_value_in,
  output logic                           tbl_insert,
  output logic                           tbl_lookup,
  input  logic [VALUE_WIDTH-1:0]         tbl_value_out,
  input  logic                           tbl_found,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           lookup_hits,
  output logic [CNT_WIDTH-1:0]           lookup_misses
);

  state_t               state, next_state;
  logic [REQ_IDX_W-1:0] rr_ptr;
  logic [REQ_IDX_W-1:0] cur_idx;
  logic                 cur_op;
  logic [NUM_REQ-1:0]   grant;
  logic [REQ_IDX_W-1:0] grant_idx;
  logic                 any_grant;
  logic                 handshake;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .REQ_IDX_W(REQ_IDX_W)
  ) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any_grant(any_grant)
  );

  assign handshake = (state == IDLE) && any_grant;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: IDLE waits for a winner, the rest step unconditionally
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_grant) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs: ready only to the IDLE winner, response strobe in RESP
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = (state != IDLE);
    if (state == IDLE) req_ready = grant;
    if (state == RESP) resp_valid[cur_idx] = 1'b1;
  end

  // Latch the accepted request, fire a one-cycle table strobe, advance the pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      cur_idx      <= '0;
      cur_op       <= OP_LOOKUP;
      tbl_key      <= '0;
      tbl_value_in <= '0;
      tbl_insert   <= 1'b0;
      tbl_lookup   <= 1'b0;
    end else begin
      tbl_insert <= 1'b0;
      tbl_lookup <= 1'b0;
      if (handshake) begin
        rr_ptr       <= grant_idx + REQ_IDX_W'(1);
        cur_idx      <= grant_idx;
        cur_op       <= req_insert[grant_idx];
        tbl_key      <= req_key[int'(grant_idx)*KEY_WIDTH +: KEY_WIDTH];
        tbl_value_in <= req_value[int'(grant_idx)*VALUE_WIDTH +: VALUE_WIDTH];
        tbl_insert   <= (req_insert[grant_idx] == OP_INSERT);
        tbl_lookup   <= (req_insert[grant_idx] == OP_LOOKUP);
      end
    end
  end

  // Capture the table result in WAIT and keep saturating lookup statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_found    <= 1'b0;
      resp_value    <= '0;
      lookup_hits   <= '0;
      lookup_misses <= '0;
    end else if (state == WAIT) begin
      resp_found <= tbl_found;
      resp_value <= tbl_value_out;
      if (cur_op == OP_LOOKUP) begin
        if (tbl_found) begin
          if (lookup_hits != '1) lookup_hits <= lookup_hits + CNT_WIDTH'(1);
        end else begin
          if (lookup_misses != '1) lookup_misses <= lookup_misses + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_table_arbiter.sv
// tb/tb_hash_table_arbiter.sv - directed bench with a small direct-mapped table model
module tb_hash_table_arbiter;

  localparam int NR = 4;
  localparam int KW = 32;
  localparam int VW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_insert = '0;
  logic [NR*KW-1:0] req_key = '0;
  logic [NR*VW-1:0] req_value = '0;
  logic [NR-1:0]   resp_valid;
  logic            resp_found;
  logic [VW-1:0]   resp_value;
  logic [KW-1:0]   tbl_key;
  logic [VW-1:0]   tbl_value_in;
  logic            tbl_insert;
  logic            tbl_lookup;
  logic [VW-1:0]   tbl_value_out = '0;
  logic            tbl_found = 1'b0;
  logic            busy;
  logic [CW-1:0]   lookup_hits;
  logic [CW-1:0]   lookup_misses;

  int total = 0;
  int bad = 0;

  hash_table_arbiter #(
    .NUM_REQ(NR), .REQ_IDX_W(2), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_insert(req_insert),
    .req_key(req_key), .req_value(req_value),
    .resp_valid(resp_valid), .resp_found(resp_found), .resp_value(resp_value),
    .tbl_key(tbl_key), .tbl_value_in(tbl_value_in),
    .tbl_insert(tbl_insert), .tbl_lookup(tbl_lookup),
    .tbl_value_out(tbl_value_out), .tbl_found(tbl_found),
    .busy(busy), .lookup_hits(lookup_hits), .lookup_misses(lookup_misses)
  );

  always #5 clk = ~clk;

  // Table model: 16 direct-mapped slots indexed by key[3:0], one-cycle registered result
  logic [KW-1:0] mem_key [16];
  logic [VW-1:0] mem_val [16];
  logic          mem_v   [16];
  initial for (int i = 0; i < 16; i++) begin
    mem_key[i] = '0; mem_val[i] = '0; mem_v[i] = 1'b0;
  end
  always @(posedge clk) begin
    if (tbl_insert) begin
      mem_key[tbl_key[3:0]] <= tbl_key;
      mem_val[tbl_key[3:0]] <= tbl_value_in;
      mem_v[tbl_key[3:0]]   <= 1'b1;
      tbl_found     <= 1'b1;
      tbl_value_out <= tbl_value_in;
    end else if (tbl_lookup) begin
      if (mem_v[tbl_key[3:0]] && mem_key[tbl_key[3:0]] == tbl_key) begin
        tbl_found     <= 1'b1;
        tbl_value_out <= mem_val[tbl_key[3:0]];
      end else begin
        tbl_found     <= 1'b0;
        tbl_value_out <= '0;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic ins, input logic [KW-1:0] key, input logic [VW-1:0] val);
    req_insert[r]         = ins;
    req_key[r*KW +: KW]   = key;
    req_value[r*VW +: VW] = val;
    req_valid[r]          = 1'b1;
  endtask

  // One full transaction from a single requester, checking every stage's timing
  task automatic run_txn(input int r, input logic ins, input logic [KW-1:0] key,
                         input logic [VW-1:0] val, input logic ef, input logic [VW-1:0] ev,
                         input int eh, input int em);
    int n;
    @(negedge clk);
    drive(r, ins, key, val);
    #1;
    n = 0;
    while (req_ready != (NR'(1) << r) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      check("ready_timeout", 64'(req_ready), 64'(NR'(1) << r));
      req_valid = '0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    check("issue_insert", 64'(tbl_insert), 64'(ins));
    check("issue_lookup", 64'(tbl_lookup), 64'(!ins));
    check("issue_key", 64'(tbl_key), 64'(key));
    if (ins) check("issue_val", 64'(tbl_value_in), 64'(val));
    check("issue_ready0", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("wait_strobes", 64'({tbl_insert, tbl_lookup}), 64'd0);
    check("wait_resp0", 64'(resp_valid), 64'd0);
    @(negedge clk);
    check("resp_valid", 64'(resp_valid), 64'(NR'(1) << r));
    check("resp_found", 64'(resp_found), 64'(ef));
    check("resp_value", 64'(resp_value), 64'(ev));
    check("hits", 64'(lookup_hits), 64'(eh));
    check("misses", 64'(lookup_misses), 64'(em));
    @(negedge clk);
    check("post_resp0", 64'(resp_valid), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
  endtask

  typedef struct {
    int          r;
    logic        ins;
    logic [31:0] key;
    logic [31:0] val;
    logic        ef;
    logic [31:0] ev;
    int          eh;
    int          em;
  } vec_t;

  vec_t vecs[8];
  int   gseq[$];
  int   gcyc[$];

  initial begin
    vecs[0] = '{0, 1'b1, 32'h15, 32'hAA,   1'b1, 32'hAA,   0, 0};
    vecs[1] = '{2, 1'b0, 32'h15, 32'h0,    1'b1, 32'hAA,   1, 0};
    vecs[2] = '{1, 1'b0, 32'h25, 32'h0,    1'b0, 32'h0,    1, 1};
    vecs[3] = '{3, 1'b1, 32'h37, 32'h1234, 1'b1, 32'h1234, 1, 1};
    vecs[4] = '{3, 1'b0, 32'h37, 32'h0,    1'b1, 32'h1234, 2, 1};
    vecs[5] = '{0, 1'b1, 32'h25, 32'h55,   1'b1, 32'h55,   2, 1};
    vecs[6] = '{1, 1'b0, 32'h15, 32'h0,    1'b0, 32'h0,    2, 2};
    vecs[7] = '{2, 1'b0, 32'h25, 32'h0,    1'b1, 32'h55,   3, 2};

    // Reset values
    #12;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp", 64'(resp_valid), 64'd0);
    check("rst_strobes", 64'({tbl_insert, tbl_lookup}), 64'd0);
    check("rst_key", 64'(tbl_key), 64'd0);
    check("rst_found_val", 64'({resp_found, resp_value}), 64'd0);
    check("rst_cnt", 64'({lookup_hits, lookup_misses}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].r, vecs[i].ins, vecs[i].key, vecs[i].val,
              vecs[i].ef, vecs[i].ev, vecs[i].eh, vecs[i].em);

    // Reset asserted during WAIT discards the response and clears state
    @(negedge clk);
    drive(1, 1'b0, 32'h15, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", 64'({tbl_insert, tbl_lookup}), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cnt", 64'({lookup_hits, lookup_misses}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      check("midrst_noresp", 64'(resp_valid), 64'd0);
    end
    run_txn(1, 1'b1, 32'h44, 32'h99, 1'b1, 32'h99, 0, 0);

    // Fairness from a fresh pointer with all requesters holding valid
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NR; r++) drive(r, 1'b0, 32'h37, 32'h0);
    for (int c = 0; c < 22; c++) begin
      #1;
      check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      for (int r = 0; r < NR; r++)
        if (req_ready[r]) begin gseq.push_back(r); gcyc.push_back(c); end
      @(negedge clk);
    end
    req_valid = '0;
    check("fair_count", 64'(gseq.size()), 64'd6);
    for (int k = 0; k < gseq.size() && k < 6; k++) begin
      check("fair_order", 64'(gseq[k]), 64'(k % NR));
      check("fair_cycle", 64'(gcyc[k]), 64'(4 * k));
    end
    repeat (4) @(negedge clk);

    // Pointer wrap: pointer sits at 2, lone req 3 then lone req 0
    run_txn(3, 1'b0, 32'h37, 32'h0, 1'b1, 32'h1234, 7, 0);
    run_txn(0, 1'b0, 32'h99, 32'h0, 1'b0, 32'h0, 7, 1);
    @(negedge clk);
    req_valid = 4'b1011;
    #1;
    check("ptr_after_wrap", 64'(req_ready), 64'b0010);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Miss counter saturates at all-ones
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++)
      run_txn(i % NR, 1'b0, 32'h79, 32'h0, 1'b0, 32'h0, 0, (i + 1 > 15) ? 15 : i + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/hash_table_arbiter.md
Name: hash_table_arbiter

Overview:
- Shares one single-ported, single-cycle-latency hash table among NUM_REQ requesters.
- Each requester issues insert or lookup transactions with a valid/ready handshake.
- Grants are round-robin, one transaction in flight at a time.
- Drives the table's key/value/insert/lookup strobes, captures its registered result, and returns a one-cycle response tagged to the granted requester.
- Keeps hit/miss statistics for software visibility.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, 2..16)
- REQ_IDX_W, 2, log2(NUM_REQ)
- KEY_WIDTH, 32, key width; matches the table
- VALUE_WIDTH, 32, value width; matches the table
- CNT_WIDTH, 16, width of statistics counters

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_insert  in  NUM_REQ  per-requester op: 1 = insert, 0 = lookup
- req_key  in  NUM_REQ*KEY_WIDTH  packed keys; requester i at [i*KEY_WIDTH +: KEY_WIDTH]
- req_value  in  NUM_REQ*VALUE_WIDTH  packed insert data, same packing
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- resp_found  out  1  table found flag for the response
- resp_value  out  VALUE_WIDTH  table value for the response
- tbl_key  out  KEY_WIDTH  to table key
- tbl_value_in  out  VALUE_WIDTH  to table value_in
- tbl_insert  out  1  to table insert strobe
- tbl_lookup  out  1  to table lookup strobe
- tbl_value_out  in  VALUE_WIDTH  from table, valid the cycle after a strobe
- tbl_found  in  1  from table, valid the cycle after a strobe
- busy  out  1  high whenever state is not IDLE
- lookup_hits  out  CNT_WIDTH  lookups returning found=1
- lookup_misses  out  CNT_WIDTH  lookups returning found=0

Behaviour:
- Reset values (async, rst_n low):
  - state IDLE, rr pointer 0
  - req_ready 0, resp_valid 0, resp_found 0, resp_value 0
  - tbl_insert/tbl_lookup 0, tbl_key/tbl_value_in 0
  - counters 0, busy 0
- FSM states IDLE, ISSUE, WAIT, RESP; each transition takes exactly one cycle.
- IDLE:
  - Round-robin arbiter picks the first requester with req_valid set, searching from rr pointer upward with wrap.
  - req_ready[g] = 1 combinationally for the winner only; req_ready is 0 in all other states.
  - On handshake, latch g, op, key and value into internal registers; go to ISSUE; rr pointer becomes (g+1) mod NUM_REQ.
  - No request valid: stay in IDLE, pointer unchanged.
- ISSUE:
  - tbl_key/tbl_value_in driven from the latch.
  - Exactly one of tbl_insert or tbl_lookup high, registered, for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - Strobes low; tbl_found/tbl_value_out are valid this cycle.
  - Register them into resp_found/resp_value.
  - For lookups, increment lookup_hits or lookup_misses.
  - Go to RESP.
- RESP:
  - resp_valid[g] = 1 for one cycle; resp_found/resp_value hold until the next response.
  - No backpressure: requesters must accept.
  - Go to IDLE.
- Latency: handshake at edge N, strobe high cycle N+1, resp_valid high cycle N+3; throughput one transaction per 4 cycles.
- Insert response returns found=1 and value = inserted value; the table reports this.
- Counters saturate at all-ones; they do not wrap.
- Requests must hold key/value/op stable while valid and not ready; a drop of req_valid before handshake is allowed.
- Reset mid-transaction: FSM returns to IDLE immediately, strobes drop, pending response discarded; table contents are not the arbiter's concern.
- Out-of-range grant is impossible by construction; NUM_REQ must be a power of two.

Decomposition:
- Package hash_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), op constants (OP_LOOKUP=0, OP_INSERT=1).
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single insert: req 0 inserts key 0x15 value 0xAA → tbl_insert high 1 cycle with key 0x15; resp_valid=0001 three cycles after handshake, found=1, value 0xAA.
- Lookup hit/miss: after the insert above, req 2 looks up 0x15 → found=1, value 0xAA, lookup_hits=1; lookup 0x25 (same index, different key) → found=0, value 0, lookup_misses=1.
- Fairness: all 4 requesters hold valid continuously → grant order 0,1,2,3,0,1; one grant per 4 cycles; req_ready never multi-hot.
- Pointer wrap and idle: only req 3 valid, then only req 0 → grants 3 then 0; pointer reads 1 afterwards; IDLE with no valid holds busy=0.
- Reset mid-operation: assert rst_n low during WAIT → no resp_valid produced, strobes 0, counters 0; next request completes normally.
- Saturation: CNT_WIDTH=4, 17 missing lookups → lookup_misses stays 15.
